// File: rtl/intc.sv
// Three-source interrupt controller: two synchronised edge lines plus a periodic timer.
// Define INTC_TIMER_EN to build the timer source; otherwise pending[2] stays 0.
module intc #(
    parameter logic [15:0] TIMER_PERIOD = 16'd50000,
    parameter logic [9:0]  VEC_INTR1    = 10'd1,
    parameter logic [9:0]  VEC_INTR2    = 10'd2,
    parameter logic [9:0]  VEC_TIMER    = 10'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       intr1,
    input  logic       intr2,
    input  logic       timer_e,
    input  logic       mask_we,
    input  logic [2:0] mask_in,
    input  logic       ack,
    input  logic       reti,
    output logic       irq,
    output logic [9:0] vector,
    output logic [2:0] pending,
    output logic [2:0] in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t     state;
    logic [1:0] sync1, sync2, sync3;
    logic [1:0] rise;
    logic       tick;
    logic [2:0] mask;
    logic [2:0] src;
    logic [2:0] eligible;
    logic [2:0] pick;
    logic [9:0] pick_vec;
    logic [2:0] clr;
    logic [2:0] set;

`ifdef INTC_TIMER_EN
    localparam logic [2:0] SRC_EN = 3'b111;
    logic [15:0] count;

    assign tick = timer_e && (count == TIMER_PERIOD - 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 16'd0;
        end else if (timer_e) begin
            count <= tick ? 16'd0 : count + 16'd1;
        end
    end
`else
    localparam logic [2:0] SRC_EN = 3'b011;
    logic unused_timer_e;

    assign tick           = 1'b0;
    assign unused_timer_e = timer_e;
`endif

    // Third flop only remembers the previous synchronised level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
            sync3 <= 2'b00;
        end else begin
            sync1 <= {intr2, intr1};
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise     = sync2 & ~sync3;
    assign set      = {tick, rise};
    assign clr      = (state == REQ && ack) ? src : 3'b000;
    assign eligible = pending & mask;

    always_comb begin
        pick     = 3'b000;
        pick_vec = VEC_INTR1;
        if (eligible[0]) begin
            pick     = 3'b001;
            pick_vec = VEC_INTR1;
        end else if (eligible[1]) begin
            pick     = 3'b010;
            pick_vec = VEC_INTR2;
        end else if (eligible[2]) begin
            pick     = 3'b100;
            pick_vec = VEC_TIMER;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask <= 3'b000;
        end else if (mask_we) begin
            mask <= mask_in & SRC_EN;
        end
    end

    // A fresh edge on the acknowledge cycle survives the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 3'b000;
        end else begin
            pending <= (pending & ~clr) | set;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            src        <= 3'b000;
            irq        <= 1'b0;
            vector     <= VEC_INTR1;
            in_service <= 3'b000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|eligible) begin
                        state  <= REQ;
                        src    <= pick;
                        vector <= pick_vec;
                        irq    <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack) begin
                        state      <= SERVICE;
                        irq        <= 1'b0;
                        in_service <= src;
                    end
                end
                SERVICE: begin
                    if (reti) begin
                        state      <= IDLE;
                        in_service <= 3'b000;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intc.sv
// Vector-table bench for intc with a queue of expected outputs per cycle.
// Timer rows depend on whether INTC_TIMER_EN is defined for the build.
module tb_intc;

    logic       clk;
    logic       reset;
    logic       intr1, intr2, timer_e, mask_we, ack, reti;
    logic [2:0] mask_in;
    logic       irq;
    logic [9:0] vector;
    logic [2:0] pending, in_service;

    intc #(.TIMER_PERIOD(16'd4)) dut (
        .clk(clk), .reset(reset), .intr1(intr1), .intr2(intr2),
        .timer_e(timer_e), .mask_we(mask_we), .mask_in(mask_in),
        .ack(ack), .reti(reti), .irq(irq), .vector(vector),
        .pending(pending), .in_service(in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       i1, i2, te, we;
        logic [2:0] mk;
        logic       ak, rt;
        logic       irq;
        logic [9:0] vec;
        logic [2:0] pnd, isv;
    } vec_t;

    typedef struct {
        logic       irq;
        logic [9:0] vec;
        logic [2:0] pnd, isv;
    } out_t;

    vec_t tab[$];
    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t v(logic i1, logic i2, logic te, logic we,
                               logic [2:0] mk, logic ak, logic rt,
                               logic iq, logic [9:0] vc,
                               logic [2:0] pn, logic [2:0] is);
        vec_t r;
        r.i1 = i1; r.i2 = i2; r.te = te; r.we = we; r.mk = mk;
        r.ak = ak; r.rt = rt; r.irq = iq; r.vec = vc;
        r.pnd = pn; r.isv = is;
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(string nm, out_t e);
        chk({nm, "_irq"}, int'(irq), int'(e.irq));
        chk({nm, "_vec"}, int'(vector), int'(e.vec));
        chk({nm, "_pnd"}, int'(pending), int'(e.pnd));
        chk({nm, "_isv"}, int'(in_service), int'(e.isv));
    endtask

    task automatic run(int lo, int hi);
        out_t e;
        for (int k = lo; k < hi; k++) begin
            @(negedge clk);
            intr1   = tab[k].i1;
            intr2   = tab[k].i2;
            timer_e = tab[k].te;
            mask_we = tab[k].we;
            mask_in = tab[k].mk;
            ack     = tab[k].ak;
            reti    = tab[k].rt;
            exp_q.push_back('{tab[k].irq, tab[k].vec, tab[k].pnd, tab[k].isv});
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL row%0d scoreboard empty", k);
            end else begin
                e = exp_q.pop_front();
                chk_out($sformatf("row%0d", k), e);
            end
        end
    endtask

    out_t rst_o;
    int   mid;

    initial begin
        rst_o = '{1'b0, 10'd1, 3'b000, 3'b000};
        reset = 1'b0;
        intr1 = 0; intr2 = 0; timer_e = 0; mask_we = 0;
        mask_in = 3'b000; ack = 0; reti = 0;

        // single intr1 through ack and reti
        tab.push_back(v(0,0,0,1,3'b001,0,0, 0,1,3'b000,3'b000));
        tab.push_back(v(1,0,0,0,3'b000,0,0, 0,1,3'b000,3'b000));
        tab.push_back(v(1,0,0,0,3'b000,0,0, 0,1,3'b000,3'b000));
        tab.push_back(v(1,0,0,0,3'b000,0,0, 0,1,3'b001,3'b000));
        tab.push_back(v(1,0,0,0,3'b000,0,0, 1,1,3'b001,3'b000));
        tab.push_back(v(1,0,0,0,3'b000,1,0, 0,1,3'b000,3'b001));
        tab.push_back(v(0,0,0,0,3'b000,0,0, 0,1,3'b000,3'b001));
        tab.push_back(v(0,0,0,0,3'b000,0,1, 0,1,3'b000,3'b000));
        tab.push_back(v(0,0,0,0,3'b000,0,0, 0,1,3'b000,3'b000));
        // simultaneous intr1/intr2, priority order
        tab.push_back(v(0,0,0,1,3'b111,0,0, 0,1,3'b000,3'b000));
        tab.push_back(v(1,1,0,0,3'b000,0,0, 0,1,3'b000,3'b000));
        tab.push_back(v(1,1,0,0,3'b000,0,0, 0,1,3'b000,3'b000));
        tab.push_back(v(1,1,0,0,3'b000,0,0, 0,1,3'b011,3'b000));
        tab.push_back(v(1,1,0,0,3'b000,0,0, 1,1,3'b011,3'b000));
        tab.push_back(v(1,1,0,0,3'b000,1,0, 0,1,3'b010,3'b001));
        tab.push_back(v(1,1,0,0,3'b000,0,1, 0,1,3'b010,3'b000));
        tab.push_back(v(1,1,0,0,3'b000,0,0, 1,2,3'b010,3'b000));
        tab.push_back(v(1,1,0,0,3'b000,1,0, 0,2,3'b000,3'b010));
        tab.push_back(v(1,1,0,0,3'b000,0,1, 0,2,3'b000,3'b000));
        tab.push_back(v(0,0,0,0,3'b000,0,0, 0,2,3'b000,3'b000));
        // masked intr2, then unmask
        tab.push_back(v(0,0,0,1,3'b000,0,0, 0,2,3'b000,3'b000));
        tab.push_back(v(0,1,0,0,3'b000,0,0, 0,2,3'b000,3'b000));
        tab.push_back(v(0,1,0,0,3'b000,0,0, 0,2,3'b000,3'b000));
        tab.push_back(v(0,1,0,0,3'b000,0,0, 0,2,3'b010,3'b000));
        tab.push_back(v(0,1,0,0,3'b000,0,0, 0,2,3'b010,3'b000));
        tab.push_back(v(0,1,0,1,3'b010,0,0, 0,2,3'b010,3'b000));
        tab.push_back(v(0,1,0,0,3'b000,0,0, 1,2,3'b010,3'b000));
        // frozen REQ, new edge on the ack edge, stray ack/reti
        tab.push_back(v(0,0,0,0,3'b000,0,0, 1,2,3'b010,3'b000));
        tab.push_back(v(0,0,0,1,3'b000,0,0, 1,2,3'b010,3'b000));
        tab.push_back(v(0,1,0,0,3'b000,0,0, 1,2,3'b010,3'b000));
        tab.push_back(v(0,1,0,0,3'b000,0,0, 1,2,3'b010,3'b000));
        tab.push_back(v(0,1,0,0,3'b000,1,0, 0,2,3'b010,3'b010));
        tab.push_back(v(0,1,0,0,3'b000,1,0, 0,2,3'b010,3'b010));
        tab.push_back(v(0,1,0,0,3'b000,0,1, 0,2,3'b010,3'b000));
        tab.push_back(v(0,1,0,0,3'b000,0,1, 0,2,3'b010,3'b000));
        tab.push_back(v(0,1,0,1,3'b011,1,0, 0,2,3'b010,3'b000));
        tab.push_back(v(0,1,0,0,3'b000,0,0, 1,2,3'b010,3'b000));
        tab.push_back(v(0,0,0,0,3'b000,1,0, 0,2,3'b000,3'b010));
        mid = tab.size();
        // after reset: stray strobes ignored
        tab.push_back(v(0,0,0,1,3'b011,1,1, 0,1,3'b000,3'b000));
        tab.push_back(v(0,0,0,0,3'b000,1,1, 0,1,3'b000,3'b000));
        tab.push_back(v(0,0,0,0,3'b000,1,1, 0,1,3'b000,3'b000));
`ifdef INTC_TIMER_EN
        tab.push_back(v(0,0,0,1,3'b100,0,0, 0,1,3'b000,3'b000));
        tab.push_back(v(0,0,1,0,3'b000,0,0, 0,1,3'b000,3'b000));
        tab.push_back(v(0,0,1,0,3'b000,0,0, 0,1,3'b000,3'b000));
        tab.push_back(v(0,0,0,0,3'b000,0,0, 0,1,3'b000,3'b000));
        tab.push_back(v(0,0,0,0,3'b000,0,0, 0,1,3'b000,3'b000));
        tab.push_back(v(0,0,1,0,3'b000,0,0, 0,1,3'b000,3'b000));
        tab.push_back(v(0,0,1,0,3'b000,0,0, 0,1,3'b100,3'b000));
        tab.push_back(v(0,0,1,0,3'b000,0,0, 1,3,3'b100,3'b000));
        tab.push_back(v(0,0,1,0,3'b000,1,0, 0,3,3'b000,3'b100));
        tab.push_back(v(0,0,1,0,3'b000,0,0, 0,3,3'b000,3'b100));
        tab.push_back(v(0,0,1,0,3'b000,0,0, 0,3,3'b100,3'b100));
        tab.push_back(v(0,0,0,0,3'b000,0,1, 0,3,3'b100,3'b000));
        tab.push_back(v(0,0,0,0,3'b000,0,0, 1,3,3'b100,3'b000));
        tab.push_back(v(0,0,0,0,3'b000,1,0, 0,3,3'b000,3'b100));
        tab.push_back(v(0,0,0,0,3'b000,0,1, 0,3,3'b000,3'b000));
`else
        tab.push_back(v(0,0,1,1,3'b111,0,0, 0,1,3'b000,3'b000));
        for (int k = 0; k < 7; k++)
            tab.push_back(v(0,0,1,0,3'b000,0,0, 0,1,3'b000,3'b000));
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", rst_o);
        @(negedge clk);
        reset = 1'b1;

        run(0, mid);

        // asynchronous reset while in SERVICE
        @(negedge clk);
        intr1 = 0; intr2 = 0; ack = 0; reti = 0; mask_we = 0;
        #2;
        reset = 1'b0;
        #1;
        chk_out("rst_async", rst_o);
        @(posedge clk);
        #1;
        chk_out("rst_hold", rst_o);
        @(negedge clk);
        reset = 1'b1;

        run(mid, tab.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intc.md
INTC -- requirements
Module: intc

Interface
REQ-001 Parameter: TIMER_PERIOD, 16'd50000, timer interrupt period in clk cycles while timer_e=1; legal range 1..65535.
REQ-002 Parameter: VEC_INTR1, 10'd1, PC vector for intr1.
REQ-003 Parameter: VEC_INTR2, 10'd2, PC vector for intr2.
REQ-004 Parameter: VEC_TIMER, 10'd3, PC vector for timer interrupt.
REQ-005 Port: clk  input  1  single clock, all state on rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-low reset.
REQ-007 Port: intr1, intr2  input  1 each  asynchronous external interrupt lines, rising-edge triggered.
REQ-008 Port: timer_e  input  1  timer count enable from control unit.
REQ-009 Port: mask_we  input  1  mask register write strobe.
REQ-010 Port: mask_in  input  3  new mask; bit0 intr1, bit1 intr2, bit2 timer; 1 = enabled.
REQ-011 Port: ack  input  1  control unit has taken the interrupt (PC pushed, jump to vector) this cycle.
REQ-012 Port: reti  input  1  return-from-interrupt executed this cycle.
REQ-013 Port: irq  output  1  interrupt request to control unit.
REQ-014 Port: vector  output  10  jump target for the request in progress.
REQ-015 Port: pending  output  3  latched pending sources, same bit order as mask_in.
REQ-016 Port: in_service  output  3  one-hot source currently being serviced, 0 when none.

Function
REQ-017 intr1/intr2 each pass a 2-flop synchronizer plus rising-edge detector; input high before edge 1 sets its pending bit at edge 3; a level held high sets it once.
REQ-018 Timer: 16-bit counter, holds when timer_e=0; when timer_e=1 increments, at TIMER_PERIOD-1 wraps to 0 and sets pending[2] on the same edge.
REQ-019 Mask register: mask_in written on edge where mask_we=1; masking never clears pending bits.
REQ-020 Eligible = pending & mask; priority intr1 > intr2 > timer.
REQ-021 FSM states IDLE, REQ, SERVICE; irq = 1 exactly in REQ (registered, no combinational path from inputs).
REQ-022 IDLE: if eligible != 0, go to REQ and latch highest-priority source and its vector; else stay.
REQ-023 REQ: irq held and latched source/vector frozen regardless of mask or new pending; on ack clear that pending bit, set its in_service bit, go to SERVICE.
REQ-024 SERVICE: irq=0, no nesting; on reti clear in_service, go to IDLE; next request possible one cycle later.
REQ-025 ack outside REQ and reti outside SERVICE are ignored.
REQ-026 Set and clear of the same pending bit on one edge: set wins.
REQ-027 vector holds last latched value outside REQ (VEC_INTR1 after reset).

Reset
REQ-028 reset=0 asynchronously forces: state IDLE, pending 0, in_service 0, mask 3'b000, timer count 0, synchronizers 0, irq 0, vector VEC_INTR1.
REQ-029 Reset mid-request or mid-service abandons it; no interrupt is reissued after release until a new edge or timer expiry.

Configuration
REQ-030 Macro INTC_TIMER_EN defined: timer counter and pending[2] source present as in REQ-018.
REQ-031 INTC_TIMER_EN undefined: no timer counter; pending[2] and in_service[2] constant 0; timer_e and mask_in[2] ignored; port list unchanged.

Verification
REQ-032 Mask 3'b001, intr1 rises -> pending=001 at edge 3, irq=1 and vector=1 at edge 4; ack -> pending=000, in_service=001, irq=0.
REQ-033 Mask 3'b111, intr1 and intr2 rise together -> vector=1 first; after ack+reti, irq reasserts with vector=2.
REQ-034 TIMER_PERIOD=4, timer_e=1, mask 3'b100 -> pending[2] set every 4 cycles; irq with vector=3; timer_e=0 freezes count.
REQ-035 Mask 3'b000, intr2 rises -> pending=010, irq stays 0; write mask 3'b010 -> irq=1 next-but-one edge, vector=2.
REQ-036 In REQ for intr2, new intr2 edge lands on ack edge -> pending[1] stays 1, in_service=010.
REQ-037 reset=0 during SERVICE -> all outputs to REQ-028 values immediately without waiting for clk; stray ack/reti after release ignored.
